reg_file_2r1w: RTL and testbench

//  Parametrised register file: DEPTH entries of WIDTH bits, one write port, two read ports.

---
 rtl/reg_file_if.sv | 34 +++
 rtl/reg_file_2r1w.sv | 108 ++++++++++
 tb/tb_reg_file_2r1w.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_if
// Purpose  : Write/read/clear bus of the 2-read 1-write register file.
// Revision : 1.0  initial release
// ============================================================================
interface reg_file_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic             clr_start;
    logic             clr_busy;
    logic             clr_done;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, clr_start,
        input  rdata_a, rdata_b, clr_busy, clr_done
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, clr_start,
        output rdata_a, rdata_b, clr_busy, clr_done
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_2r1w
// Purpose  : DEPTH x WIDTH register file, 1 write / 2 combinational read ports,
//            optional write-to-read bypass and a sequenced bulk-clear engine.
// Revision : 1.0  initial release
// ============================================================================
module reg_file_2r1w #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 16,
    parameter bit               BYPASS    = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic      clk,
    input  logic      rst,
    reg_file_if.slave bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_idx;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_wr_en;
    logic [WIDTH-1:0] w_mem_a;
    logic [WIDTH-1:0] w_mem_b;

    // Gating with rst keeps the bypass path from leaking wdata while in reset.
    assign w_wr_en = bus.we && !r_busy && !rst && ({1'b0, bus.waddr} < c_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_start) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_idx == c_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_idx] <= RESET_VAL;
        end else if (w_wr_en) begin
            r_mem[bus.waddr] <= bus.wdata;
        end
    end

    assign w_mem_a = ({1'b0, bus.raddr_a} < c_DEPTH) ? r_mem[bus.raddr_a] : '0;
    assign w_mem_b = ({1'b0, bus.raddr_b} < c_DEPTH) ? r_mem[bus.raddr_b] : '0;

    generate
        if (BYPASS) begin : g_bypass
            assign bus.rdata_a = (w_wr_en && (bus.waddr == bus.raddr_a)) ? bus.wdata : w_mem_a;
            assign bus.rdata_b = (w_wr_en && (bus.waddr == bus.raddr_b)) ? bus.wdata : w_mem_b;
        end else begin : g_no_bypass
            assign bus.rdata_a = w_mem_a;
            assign bus.rdata_b = w_mem_b;
        end
    endgenerate

    assign bus.clr_busy = r_busy;
    assign bus.clr_done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_2r1w
// Purpose  : Directed self-checking bench for reg_file_2r1w (DEPTH 16 bypass,
//            DEPTH 10 no-bypass with non-zero reset value).
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_2r1w;
    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    reg_file_if #(.WIDTH(8), .DEPTH(16)) b16 ();
    reg_file_if #(.WIDTH(8), .DEPTH(10)) b10 ();

    reg_file_2r1w #(.WIDTH(8), .DEPTH(16), .BYPASS(1'b1), .RESET_VAL(8'h00)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    reg_file_2r1w #(.WIDTH(8), .DEPTH(10), .BYPASS(1'b0), .RESET_VAL(8'h3C)) u_dut10 (
        .clk (clk),
        .rst (rst),
        .bus (b10)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Returns 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        b16.we = 1'b0; b16.waddr = '0; b16.wdata = '0;
        b16.raddr_a = '0; b16.raddr_b = '0; b16.clr_start = 1'b0;
        b10.we = 1'b0; b10.waddr = '0; b10.wdata = '0;
        b10.raddr_a = '0; b10.raddr_b = '0; b10.clr_start = 1'b0;

        // ---- reset state ----
        #12;
        check("rst_rdata16", b16.rdata_a, 32'h00);
        check("rst_rdata10", b10.rdata_a, 32'h3C);
        check("rst_busy",    b16.clr_busy, 32'h0);
        check("rst_done",    b16.clr_done, 32'h0);
        rst = 1'b0;

        // ---- preload, then asynchronous mid-cycle reset ----
        tick();
        for (int i = 0; i < 16; i++) begin
            b16.we = 1'b1; b16.waddr = 4'(i); b16.wdata = 8'(i * 7 + 1);
            tick();
        end
        b16.we = 1'b0;
        b16.raddr_a = 4'd5; b16.raddr_b = 4'd15;
        #1;
        check("preload_a5",  b16.rdata_a, 32'd36);
        check("preload_b15", b16.rdata_b, 32'd106);
        rst = 1'b1;
        #1;
        check("async_rst_a", b16.rdata_a, 32'h00);
        check("async_rst_b", b16.rdata_b, 32'h00);
        check("async_rst_busy", b16.clr_busy, 32'h0);
        rst = 1'b0;
        tick();

        // ---- same-cycle bypass vs old data, then visible next cycle ----
        b16.we = 1'b1; b16.waddr = 4'd3; b16.wdata = 8'hA5; b16.raddr_a = 4'd3; b16.raddr_b = 4'd4;
        b10.we = 1'b1; b10.waddr = 4'd3; b10.wdata = 8'hA5; b10.raddr_a = 4'd3; b10.raddr_b = 4'd3;
        #1;
        check("bypass_on_a",  b16.rdata_a, 32'hA5);
        check("bypass_on_b",  b16.rdata_b, 32'h00);
        check("bypass_off_a", b10.rdata_a, 32'h3C);
        tick();
        b16.we = 1'b0; b10.we = 1'b0; b16.raddr_b = 4'd3;
        #1;
        check("wr_vis16_a", b16.rdata_a, 32'hA5);
        check("wr_vis16_b", b16.rdata_b, 32'hA5);
        check("wr_vis10_a", b10.rdata_a, 32'hA5);
        check("wr_vis10_b", b10.rdata_b, 32'hA5);

        // ---- out-of-range write/read on DEPTH 10 ----
        b10.we = 1'b1; b10.waddr = 4'd12; b10.wdata = 8'h77; b10.raddr_a = 4'd12; b10.raddr_b = 4'd9;
        #1;
        check("oor_same_cycle", b10.rdata_a, 32'h00);
        tick();
        b10.we = 1'b0;
        #1;
        check("oor_read",    b10.rdata_a, 32'h00);
        check("oor_entry9",  b10.rdata_b, 32'h3C);
        b10.raddr_b = 4'd3;
        #1;
        check("oor_entry3",  b10.rdata_b, 32'hA5);

        // ---- full clear timing ----
        for (int i = 0; i < 16; i++) begin
            b16.we = 1'b1; b16.waddr = 4'(i); b16.wdata = 8'(i * 17);
            tick();
        end
        b16.we = 1'b0; b16.clr_start = 1'b1;
        tick();
        b16.clr_start = 1'b0;
        for (int j = 0; j <= 17; j++) begin
            if (j >= 1 && j <= 16) b16.raddr_a = 4'(j - 1);
            if (j < 16) b16.raddr_b = 4'(j);
            #1;
            check($sformatf("clr_busy_%0d", j), b16.clr_busy, (j <= 16) ? 32'h1 : 32'h0);
            check($sformatf("clr_done_%0d", j), b16.clr_done, (j == 16) ? 32'h1 : 32'h0);
            if (j >= 1 && j <= 16) check($sformatf("clr_cleared_%0d", j), b16.rdata_a, 32'h00);
            if (j < 16) check($sformatf("clr_pending_%0d", j), b16.rdata_b, 32'(j * 17));
            tick();
        end
        b16.raddr_a = 4'd15; b16.raddr_b = 4'd8;
        #1;
        check("clr_final_15", b16.rdata_a, 32'h00);
        check("clr_final_8",  b16.rdata_b, 32'h00);

        // ---- write and restart ignored while clearing ----
        b16.we = 1'b1; b16.waddr = 4'd15; b16.wdata = 8'h5A;
        tick();
        b16.we = 1'b0; b16.clr_start = 1'b1;
        tick();
        b16.clr_start = 1'b0;
        tick();
        b16.we = 1'b1; b16.waddr = 4'd15; b16.wdata = 8'hFF; b16.raddr_a = 4'd15;
        #1;
        check("busy_wr_nobypass", b16.rdata_a, 32'h5A);
        tick();
        b16.we = 1'b0;
        #1;
        check("busy_wr_dropped", b16.rdata_a, 32'h5A);
        tick();
        tick();
        b16.clr_start = 1'b1;
        tick();
        b16.clr_start = 1'b0;
        repeat (10) tick();
        #1;
        check("restart_done_e15", b16.clr_done, 32'h0);
        check("restart_busy_e15", b16.clr_busy, 32'h1);
        tick();
        check("restart_done_e16", b16.clr_done, 32'h1);
        tick();
        check("restart_busy_e17", b16.clr_busy, 32'h0);
        check("restart_done_e17", b16.clr_done, 32'h0);
        check("restart_addr15",   b16.rdata_a,  32'h00);
        tick();
        check("restart_idle_e18", b16.clr_busy, 32'h0);

        // ---- reset aborts a clear ----
        b16.we = 1'b1; b16.waddr = 4'd14; b16.wdata = 8'hEE;
        tick();
        b16.we = 1'b0; b16.clr_start = 1'b1;
        tick();
        b16.clr_start = 1'b0;
        repeat (7) tick();
        b16.raddr_a = 4'd14; b16.raddr_b = 4'd0;
        #1;
        check("abort_pre_busy", b16.clr_busy, 32'h1);
        check("abort_pre_14",   b16.rdata_a,  32'hEE);
        check("abort_pre_0",    b16.rdata_b,  32'h00);
        rst = 1'b1;
        #1;
        check("abort_busy",  b16.clr_busy, 32'h0);
        check("abort_done",  b16.clr_done, 32'h0);
        check("abort_14",    b16.rdata_a,  32'h00);
        check("abort_dut10", b10.rdata_b,  32'h3C);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("abort_no_done_%0d", k), b16.clr_done, 32'h0);
        end
        check("abort_idle", b16.clr_busy, 32'h0);
        check("abort_14_final", b16.rdata_a, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
